reg_dump_reader: RTL

- Read-side companion to the 32x32 MIPS register file. Replaces simulation-only file dumps with a synthesizable readout.
- On a start request it walks a register address range through one register-file read port.
- Streams each {address, data} pair out over a valid/ready handshake, for a debug/UART bridge or a testbench scoreboard.
- Sits beside the core, using a read port (A or B) while the core is halted.

---
 rtl/reg_dump_reader.sv | 134 +++++++++++++
 1 files changed

// File: rtl/reg_dump_reader.sv
// rtl/reg_dump_reader.sv - walks a register-file address range and streams {addr, data} words
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             dump request, sampled only while idle
//   first_addr        first register of the range, latched with start
//   last_addr         last register of the range (inclusive), latched with start
//   rf_addr           registered register-file read address
//   rf_data           combinational register-file read data for rf_addr
//   out_valid/ready   output word handshake
//   out_addr/out_data register index and contents of the current word
//   busy              high while words are being loaded or sent
//   done              one-cycle pulse when the dump completes
module reg_dump_reader #(
    parameter int REG_WIDTH      = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_OF_REGS    = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [REG_ADDR_WIDTH-1:0] first_addr,
    input  logic [REG_ADDR_WIDTH-1:0] last_addr,
    output logic [REG_ADDR_WIDTH-1:0] rf_addr,
    input  logic [REG_WIDTH-1:0]      rf_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [REG_ADDR_WIDTH-1:0] out_addr,
    output logic [REG_WIDTH-1:0]      out_data,
    output logic                      busy,
    output logic                      done
);

    localparam logic [REG_ADDR_WIDTH-1:0] LP_MAX_ADDR = REG_ADDR_WIDTH'(NUM_OF_REGS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_DONE
    } state_t;

    state_t                    r_state;
    state_t                    w_next_state;
    logic [REG_ADDR_WIDTH-1:0] r_cur_addr;
    logic [REG_ADDR_WIDTH-1:0] r_end_addr;
    logic [REG_ADDR_WIDTH-1:0] r_rf_addr;
    logic [REG_ADDR_WIDTH-1:0] r_out_addr;
    logic [REG_WIDTH-1:0]      r_out_data;
    logic                      r_out_valid;

    logic                      w_accept;
    logic                      w_last;
    logic [REG_ADDR_WIDTH-1:0] w_next_addr;

    assign w_accept    = r_out_valid & out_ready;
    // Also stopping at the top register keeps the walk from wrapping to 0
    // even if a range ending beyond the register file were requested.
    assign w_last      = (r_cur_addr == r_end_addr) || (r_cur_addr == LP_MAX_ADDR);
    assign w_next_addr = r_cur_addr + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = (last_addr >= first_addr) ? S_LOAD : S_DONE;
                end
            end
            S_LOAD: w_next_state = S_SEND;
            S_SEND: begin
                if (w_accept) begin
                    w_next_state = w_last ? S_DONE : S_LOAD;
                end
            end
            S_DONE: w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // rf_addr is updated one cycle ahead of LOAD so rf_data has settled
    // by the time it is captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur_addr  <= '0;
            r_end_addr  <= '0;
            r_rf_addr   <= '0;
            r_out_addr  <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cur_addr <= first_addr;
                        r_end_addr <= last_addr;
                        r_rf_addr  <= first_addr;
                    end
                end
                S_LOAD: begin
                    r_out_data  <= rf_data;
                    r_out_addr  <= r_cur_addr;
                    r_out_valid <= 1'b1;
                end
                S_SEND: begin
                    if (w_accept) begin
                        r_out_valid <= 1'b0;
                        if (!w_last) begin
                            r_cur_addr <= w_next_addr;
                            r_rf_addr  <= w_next_addr;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign rf_addr   = r_rf_addr;
    assign out_addr  = r_out_addr;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign busy      = (r_state == S_LOAD) || (r_state == S_SEND);
    assign done      = (r_state == S_DONE);

endmodule
